// File: rtl/datapath_run_monitor_pkg.sv
// Shared definitions for the datapath run monitor: state encoding and the
// signature fold step, kept here so benches and tools can reuse them.
package datapath_run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Widest signature the fold helper supports.
  localparam int SIG_MAX_W = 64;

  // One signature step: rotate left by one within w bits, then XOR in data.
  function automatic logic [SIG_MAX_W-1:0] sig_step(
    input logic [SIG_MAX_W-1:0] sig,
    input logic [SIG_MAX_W-1:0] data,
    input int unsigned          w
  );
    logic [SIG_MAX_W-1:0] mask;
    mask = (w >= SIG_MAX_W) ? '1 : ((SIG_MAX_W'(1) << w) - SIG_MAX_W'(1));
    sig_step = (((sig << 1) | (sig >> (w - 1))) & mask) ^ (data & mask);
  endfunction

endpackage

// File: rtl/datapath_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear has priority over increment; the count sticks at all-ones.
module datapath_run_monitor_sat_counter
  import datapath_run_monitor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register: clear wins, increment stops at the maximum value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/datapath_run_monitor.sv
// Run controller/observer for the pipelined datapath. Holds the core in reset
// for RST_CYCLES after Start, lets it run, counts cycles and register writes,
// folds WriteData into a rotating-XOR signature and stops on PC halt or timeout.
//
// Handshake: Start is a level sampled only in IDLE or DONE; the run's results
// are valid when Done is 1 and stay held until the next accepted Start.
module datapath_run_monitor
  import datapath_run_monitor_pkg::*;
#(
  parameter int W           = 32,
  parameter int RST_CYCLES  = 2,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [W-1:0]     PCAddResult,
  input  logic [W-1:0]     WriteData,
  input  logic [W-1:0]     ALUResult,
  input  logic             RegWrite,
  output logic             CoreRst,
  output logic             Running,
  output logic             Done,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] WriteCount,
  output logic [W-1:0]     Signature,
  output logic [W-1:0]     LastALU,
  output logic [1:0]       DbgState
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int STAB_W = $clog2(HALT_CYCLES);
  localparam logic [CNT_W:0] MAX_L = (CNT_W + 1)'(MAX_CYCLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_core_rst;
  logic              r_running;
  logic              r_done;
  logic              r_timed_out;
  logic              w_done_nxt;
  logic              w_to_nxt;
  logic [W-1:0]      r_sig;
  logic [W-1:0]      r_last_alu;
  logic [W-1:0]      r_prev_pc;
  logic              r_prev_valid;
  logic [W-1:0]      w_sig_next;
  logic              w_start_ok;
  logic              w_in_run;
  logic              w_in_hold;
  logic              w_pc_same;
  logic              w_halt;
  logic              w_timeout;
  logic              w_hold_last;
  logic [HOLD_W-1:0] w_hold_cnt;
  logic [STAB_W-1:0] w_stable;
  logic [CNT_W-1:0]  w_cycle_cnt;
  logic [CNT_W-1:0]  w_write_cnt;

  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_hold   = (r_state == ST_HOLD);
  assign w_start_ok  = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_hold_last = (w_hold_cnt == HOLD_W'(RST_CYCLES - 1));
  // The first RUN cycle has no previous PC, so r_prev_valid gates the compare.
  assign w_pc_same   = r_prev_valid && (PCAddResult == r_prev_pc);
  assign w_halt      = w_in_run && w_pc_same && (w_stable == STAB_W'(HALT_CYCLES - 2));
  assign w_timeout   = w_in_run && (w_cycle_cnt != '1) &&
                       (({1'b0, w_cycle_cnt} + (CNT_W + 1)'(1)) == MAX_L);
  assign w_sig_next  = W'(sig_step(SIG_MAX_W'(r_sig), SIG_MAX_W'(WriteData), W));

  datapath_run_monitor_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .i_clk(Clk), .i_rst(Rst), .i_clr(w_start_ok), .i_inc(w_in_run), .o_count(w_cycle_cnt)
  );

  datapath_run_monitor_sat_counter #(.WIDTH(CNT_W)) u_write_cnt (
    .i_clk(Clk), .i_rst(Rst), .i_clr(w_start_ok), .i_inc(w_in_run && RegWrite),
    .o_count(w_write_cnt)
  );

  datapath_run_monitor_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .i_clk(Clk), .i_rst(Rst), .i_clr(!w_in_hold), .i_inc(w_in_hold), .o_count(w_hold_cnt)
  );

  datapath_run_monitor_sat_counter #(.WIDTH(STAB_W)) u_stable_cnt (
    .i_clk(Clk), .i_rst(Rst), .i_clr(!(w_in_run && w_pc_same)),
    .i_inc(w_in_run && w_pc_same), .o_count(w_stable)
  );

  // Next-state and next Done/TimedOut; halt takes priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_to_nxt    = r_timed_out;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_state_nxt = ST_HOLD;
          w_done_nxt  = 1'b0;
          w_to_nxt    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (w_hold_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_to_nxt    = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_to_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and control outputs, registered from the next state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_rst  <= (w_state_nxt != ST_RUN);
      r_running   <= (w_state_nxt == ST_RUN);
      r_done      <= w_done_nxt;
      r_timed_out <= w_to_nxt;
    end
  end

  // Observed data: signature, last ALU value and previous PC for halt detect.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sig        <= '0;
      r_last_alu   <= '0;
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_start_ok) begin
      r_sig        <= '0;
      r_last_alu   <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_in_run) begin
      r_last_alu   <= ALUResult;
      r_prev_pc    <= PCAddResult;
      r_prev_valid <= 1'b1;
      if (RegWrite) r_sig <= w_sig_next;
    end else begin
      r_prev_valid <= 1'b0;
    end
  end

  assign CoreRst    = r_core_rst;
  assign Running    = r_running;
  assign Done       = r_done;
  assign TimedOut   = r_timed_out;
  assign CycleCount = w_cycle_cnt;
  assign WriteCount = w_write_cnt;
  assign Signature  = r_sig;
  assign LastALU    = r_last_alu;
  assign DbgState   = r_state;

endmodule

// File: tb/tb_datapath_run_monitor.sv
// Bench for datapath_run_monitor: directed and random runs, a reference model
// computed from the run rules, and a Done-triggered scoreboard monitor.
module tb_datapath_run_monitor;

  localparam int W           = 32;
  localparam int RST_CYCLES  = 2;
  localparam int HALT_CYCLES = 4;
  localparam int MAX_CYCLES  = 8;
  localparam int CNT_W       = 16;
  localparam int NC          = MAX_CYCLES;

  logic             Clk, Rst, Start, RegWrite;
  logic [W-1:0]     PCAddResult, WriteData, ALUResult;
  logic             CoreRst, Running, Done, TimedOut;
  logic [CNT_W-1:0] CycleCount, WriteCount;
  logic [W-1:0]     Signature, LastALU;
  logic [1:0]       DbgState;

  typedef struct packed {
    logic             timed_out;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] wr;
    logic [W-1:0]     sig;
    logic [W-1:0]     alu;
  } result_t;
  localparam int RES_W = $bits(result_t);

  logic [RES_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  // Per-RUN-cycle stimulus (index 0 = first RUN cycle) and model trace.
  logic [W-1:0] s_pc[NC];
  logic [W-1:0] s_wd[NC];
  logic [W-1:0] s_alu[NC];
  logic         s_rw[NC];
  logic [W-1:0] m_sig[NC+1];
  int           m_wr[NC+1];

  datapath_run_monitor #(
    .W(W), .RST_CYCLES(RST_CYCLES), .HALT_CYCLES(HALT_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .PCAddResult(PCAddResult),
    .WriteData(WriteData), .ALUResult(ALUResult), .RegWrite(RegWrite),
    .CoreRst(CoreRst), .Running(Running), .Done(Done), .TimedOut(TimedOut),
    .CycleCount(CycleCount), .WriteCount(WriteCount), .Signature(Signature),
    .LastALU(LastALU), .DbgState(DbgState)
  );

  // Clock and watchdog.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
    return {v[W-2:0], v[W-1]};
  endfunction

  // Reference model: the run ends at the first cycle k where the last
  // HALT_CYCLES PC samples are identical (halt) or k reaches MAX_CYCLES.
  task automatic model_run(output int kend, output result_t r);
    bit halted;
    kend   = NC;
    halted = 1'b0;
    for (int k = 1; k <= NC; k++) begin
      bit same;
      same = (k >= HALT_CYCLES);
      for (int j = k - HALT_CYCLES + 1; j < k; j++)
        if (j >= 1 && s_pc[j-1] != s_pc[k-1]) same = 1'b0;
      if (same || k == MAX_CYCLES) begin
        kend   = k;
        halted = same;
        break;
      end
    end
    m_sig[0] = '0;
    m_wr[0]  = 0;
    for (int k = 1; k <= kend; k++) begin
      m_sig[k] = s_rw[k-1] ? (rotl1(m_sig[k-1]) ^ s_wd[k-1]) : m_sig[k-1];
      m_wr[k]  = m_wr[k-1] + (s_rw[k-1] ? 1 : 0);
    end
    r.timed_out = !halted;
    r.cyc       = CNT_W'(kend);
    r.wr        = CNT_W'(m_wr[kend]);
    r.sig       = m_sig[kend];
    r.alu       = s_alu[kend-1];
  endtask

  task automatic drive_garbage();
    PCAddResult = $urandom;
    WriteData   = $urandom;
    ALUResult   = $urandom;
    RegWrite    = 1'($urandom_range(0, 1));
  endtask

  // One full run: push the expectation, start, check HOLD, drive RUN cycles.
  task automatic run_one(input bit wild);
    int      kend;
    int      n;
    result_t r;
    model_run(kend, r);
    exp_q.push_back(RES_W'(r));
    @(negedge Clk);
    Start = 1'b1;
    drive_garbage();
    @(negedge Clk);
    n = 0;
    while (!Running && n < RST_CYCLES + 4) begin
      check("hold_core_rst", 64'(CoreRst), 64'(1));
      check("hold_done_clr", 64'(Done), 64'(0));
      check("hold_to_clr", 64'(TimedOut), 64'(0));
      check("hold_cyc_clr", 64'(CycleCount), 64'(0));
      check("hold_wr_clr", 64'(WriteCount), 64'(0));
      check("hold_sig_clr", 64'(Signature), 64'(0));
      check("hold_alu_clr", 64'(LastALU), 64'(0));
      Start = wild ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_garbage();
      n++;
      @(negedge Clk);
    end
    check("hold_len", 64'(n), 64'(RST_CYCLES));
    for (int k = 1; k <= kend; k++) begin
      check("run_running", 64'(Running), 64'(1));
      check("run_core_rst", 64'(CoreRst), 64'(0));
      check("run_cyc", 64'(CycleCount), 64'(k - 1));
      check("run_sig", 64'(Signature), 64'(m_sig[k-1]));
      PCAddResult = s_pc[k-1];
      WriteData   = s_wd[k-1];
      ALUResult   = s_alu[k-1];
      RegWrite    = s_rw[k-1];
      Start       = (wild && k < kend) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge Clk);
    end
    Start = 1'b0;
    drive_garbage();
    repeat (2) @(negedge Clk);
    check("done_sticky", 64'(Done), 64'(1));
    check("done_sig_held", 64'(Signature), 64'(r.sig));
    check("done_cyc_held", 64'(CycleCount), 64'(r.cyc));
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NC; k++) begin
      s_pc[k]  = '0;
      s_wd[k]  = '0;
      s_alu[k] = W'(32'h1000 + k);
      s_rw[k]  = 1'b0;
    end
  endtask

  // Scoreboard monitor: on each Done rising, compare against the oldest expectation.
  logic prev_done = 1'b0;
  always @(negedge Clk) begin
    if (Done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got Done=1 required no pending run");
      end else begin
        result_t e;
        e = result_t'(exp_q.pop_front());
        check("end_timed_out", 64'(TimedOut), 64'(e.timed_out));
        check("end_cycle_count", 64'(CycleCount), 64'(e.cyc));
        check("end_write_count", 64'(WriteCount), 64'(e.wr));
        check("end_signature", 64'(Signature), 64'(e.sig));
        check("end_last_alu", 64'(LastALU), 64'(e.alu));
        check("end_core_rst", 64'(CoreRst), 64'(1));
        check("end_running", 64'(Running), 64'(0));
      end
    end
    prev_done = Done;
  end

  // Main stimulus sequence.
  initial begin
    int n;
    Rst = 1'b1;
    Start = 1'b0;
    PCAddResult = '0;
    WriteData = '0;
    ALUResult = '0;
    RegWrite = 1'b0;
    #3;
    check("rst_core_rst", 64'(CoreRst), 64'(1));
    check("rst_running", 64'(Running), 64'(0));
    check("rst_done", 64'(Done), 64'(0));
    check("rst_timed_out", 64'(TimedOut), 64'(0));
    check("rst_cyc", 64'(CycleCount), 64'(0));
    check("rst_sig", 64'(Signature), 64'(0));
    #9;
    Rst = 1'b0;

    // Halt: PC 4,8,12,12,12,12 ends after six RUN cycles.
    clear_stim();
    s_pc[0] = 32'd4;
    s_pc[1] = 32'd8;
    for (int k = 2; k < NC; k++) s_pc[k] = 32'd12;
    run_one(1'b0);

    // Signature: writes 0x1, 0x2, 0x80000000 with a constant PC.
    clear_stim();
    for (int k = 0; k < NC; k++) s_pc[k] = 32'd100;
    s_wd[0] = 32'h0000_0001; s_rw[0] = 1'b1;
    s_wd[1] = 32'h0000_0002; s_rw[1] = 1'b1;
    s_wd[2] = 32'h8000_0000; s_rw[2] = 1'b1;
    run_one(1'b0);

    // Timeout: PC incrementing by 4.
    clear_stim();
    for (int k = 0; k < NC; k++) s_pc[k] = W'(4 * (k + 1));
    run_one(1'b0);

    // Collision: halt condition met on the same cycle the limit is reached.
    clear_stim();
    for (int k = 0; k < 4; k++) s_pc[k] = W'(4 * (k + 1));
    for (int k = 4; k < NC; k++) s_pc[k] = 32'd20;
    s_rw[NC-1] = 1'b1;
    s_wd[NC-1] = 32'hA5A5_0001;
    run_one(1'b0);

    // Abort mid-RUN with asynchronous reset.
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (!Running && n < 10) begin
      n++;
      @(negedge Clk);
    end
    for (int k = 0; k < 3; k++) begin
      PCAddResult = W'(4 * (k + 1));
      RegWrite = 1'b1;
      WriteData = $urandom;
      ALUResult = $urandom;
      @(negedge Clk);
    end
    #2;
    Rst = 1'b1;
    #1;
    check("abort_core_rst", 64'(CoreRst), 64'(1));
    check("abort_running", 64'(Running), 64'(0));
    check("abort_done", 64'(Done), 64'(0));
    check("abort_cyc", 64'(CycleCount), 64'(0));
    check("abort_wr", 64'(WriteCount), 64'(0));
    check("abort_sig", 64'(Signature), 64'(0));
    check("abort_alu", 64'(LastALU), 64'(0));
    @(negedge Clk);
    Rst = 1'b0;
    RegWrite = 1'b0;

    // Random runs, each restarted from DONE; Start wiggled while ignored.
    for (int t = 0; t < 24; t++) begin
      int keep;
      keep = $urandom_range(0, 4);
      s_pc[0] = $urandom;
      for (int k = 0; k < NC; k++) begin
        if (k > 0) s_pc[k] = ($urandom_range(0, 4) < keep) ? s_pc[k-1] : $urandom;
        s_wd[k]  = $urandom;
        s_alu[k] = $urandom;
        s_rw[k]  = 1'($urandom_range(0, 1));
      end
      run_one(1'b1);
    end

    repeat (3) @(negedge Clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
